// File: rtl/fsm_ok_run_monitor.sv
// Run monitor for the sequence-detector ok flag.
// Pulses on run start, measures runs, reports them on a valid/ready slot.
module fsm_ok_run_monitor #(
  parameter int CNT_W   = 8,
  parameter int EVT_W   = 16,
  parameter int MIN_RUN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ok,
  input  logic             i_clr,
  input  logic             i_ready,
  output logic             o_rise,
  output logic             o_busy,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_run_len,
  output logic [EVT_W-1:0] o_evt_cnt,
  output logic [7:0]       o_drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_RUN);

  state_t           state_q;
  logic [CNT_W-1:0] run_cnt_q;

  logic end_run;
  logic qualify;
  logic xfer;
  logic load;
  logic drop;

  // End-of-run qualification and slot arbitration.
  always_comb begin
    end_run = (state_q == RUN) && !i_ok;
    qualify = end_run && (run_cnt_q >= MIN_LEN);
    xfer    = o_valid && i_ready;
    load    = qualify && (!o_valid || i_ready);
    drop    = qualify && !load;
  end

  assign o_busy = (state_q == RUN);

  // Run FSM, report slot and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      o_rise     <= 1'b0;
      o_valid    <= 1'b0;
      o_run_len  <= '0;
      o_evt_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      o_rise <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_ok) begin
            state_q   <= RUN;
            run_cnt_q <= CNT_W'(1);
            o_rise    <= 1'b1;
          end
        end
        RUN: begin
          if (i_ok) begin
            if (run_cnt_q != CNT_MAX)
              run_cnt_q <= run_cnt_q + 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        o_valid   <= 1'b1;
        o_run_len <= run_cnt_q;
      end else if (xfer) begin
        o_valid <= 1'b0;
      end

      if (i_clr) begin
        o_evt_cnt  <= '0;
        o_drop_cnt <= '0;
      end else begin
        if (load)
          o_evt_cnt <= o_evt_cnt + 1'b1;
        if (drop && (o_drop_cnt != 8'hFF))
          o_drop_cnt <= o_drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_ok_run_monitor.sv
// Directed self-checking bench for fsm_ok_run_monitor.
// Expected values are hand-computed per scenario.
module tb_fsm_ok_run_monitor;

  logic        clk;
  logic        rst;
  logic        i_ok;
  logic        i_clr;
  logic        i_ready;
  logic        o_rise;
  logic        o_busy;
  logic        o_valid;
  logic [7:0]  o_run_len;
  logic [15:0] o_evt_cnt;
  logic [7:0]  o_drop_cnt;

  int checks = 0;
  int errors = 0;

  fsm_ok_run_monitor #(
    .CNT_W(8),
    .EVT_W(16),
    .MIN_RUN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_ok(i_ok),
    .i_clr(i_clr),
    .i_ready(i_ready),
    .o_rise(o_rise),
    .o_busy(o_busy),
    .o_valid(o_valid),
    .o_run_len(o_run_len),
    .o_evt_cnt(o_evt_cnt),
    .o_drop_cnt(o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_ok = 1'b0;
    i_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_ok = 1'b1;
    i_clr = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_rise, o_busy, o_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {o_rise, o_busy, o_valid});
    end
    checks++;
    if ({o_run_len, o_evt_cnt, o_drop_cnt} !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnts got %h/%h/%h exp 0",
               o_run_len, o_evt_cnt, o_drop_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({o_rise, o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_rel_rise got %b exp 11", {o_rise, o_busy});
    end
    tick();
    checks++;
    if ({o_rise, o_busy} !== 2'b01) begin
      errors++;
      $display("FAIL reset_rise_once got %b exp 01", {o_rise, o_busy});
    end
    // Reset in mid-run drops the run without a report.
    rst = 1'b1;
    i_ok = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_valid, o_evt_cnt} !== 18'd0) begin
      errors++;
      $display("FAIL reset_midrun got busy=%b valid=%b evt=%0d exp 0",
               o_busy, o_valid, o_evt_cnt);
    end
  endtask

  task automatic test_normal();
    do_reset();
    i_ready = 1'b1;
    i_ok = 1'b1;
    tick();
    checks++;
    if (o_rise !== 1'b1) begin
      errors++;
      $display("FAIL normal_rise got %b exp 1", o_rise);
    end
    tick();
    checks++;
    if (o_rise !== 1'b0) begin
      errors++;
      $display("FAIL normal_rise_pulse got %b exp 0", o_rise);
    end
    tick();
    tick();
    tick();
    i_ok = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_busy, o_run_len} !== {1'b1, 1'b0, 8'd5}) begin
      errors++;
      $display("FAIL normal_report got v=%b b=%b len=%0d exp v=1 b=0 len=5",
               o_valid, o_busy, o_run_len);
    end
    checks++;
    if ({o_evt_cnt, o_drop_cnt} !== {16'd1, 8'd0}) begin
      errors++;
      $display("FAIL normal_cnts got evt=%0d drop=%0d exp 1/0",
               o_evt_cnt, o_drop_cnt);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL normal_xfer got %b exp 0", o_valid);
    end
  endtask

  task automatic test_glitch();
    i_ok = 1'b1;
    tick();
    checks++;
    if (o_rise !== 1'b1) begin
      errors++;
      $display("FAIL glitch_rise got %b exp 1", o_rise);
    end
    i_ok = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_valid, o_busy, o_evt_cnt, o_drop_cnt} !==
        {1'b0, 1'b0, 16'd1, 8'd0}) begin
      errors++;
      $display("FAIL glitch_drop got v=%b b=%b evt=%0d drop=%0d exp 0/0/1/0",
               o_valid, o_busy, o_evt_cnt, o_drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_ready = 1'b0;
    i_ok = 1'b1;
    repeat (3) tick();
    i_ok = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_run_len, o_evt_cnt} !== {1'b1, 8'd3, 16'd1}) begin
      errors++;
      $display("FAIL bp_first got v=%b len=%0d evt=%0d exp 1/3/1",
               o_valid, o_run_len, o_evt_cnt);
    end
    i_ok = 1'b1;
    tick();
    checks++;
    if (o_rise !== 1'b1) begin
      errors++;
      $display("FAIL bp_gap_rise got %b exp 1", o_rise);
    end
    repeat (3) tick();
    i_ok = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_run_len, o_drop_cnt, o_evt_cnt} !==
        {1'b1, 8'd3, 8'd1, 16'd1}) begin
      errors++;
      $display("FAIL bp_drop got v=%b len=%0d drop=%0d evt=%0d exp 1/3/1/1",
               o_valid, o_run_len, o_drop_cnt, o_evt_cnt);
    end
    tick();
    checks++;
    if ({o_valid, o_run_len} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL bp_hold got v=%b len=%0d exp 1/3", o_valid, o_run_len);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if ({o_valid, o_evt_cnt} !== {1'b0, 16'd1}) begin
      errors++;
      $display("FAIL bp_xfer got v=%b evt=%0d exp 0/1", o_valid, o_evt_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_ready = 1'b0;
    i_ok = 1'b1;
    repeat (3) tick();
    i_ok = 1'b0;
    tick();
    i_ok = 1'b1;
    repeat (2) tick();
    i_ok = 1'b0;
    i_ready = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_run_len, o_evt_cnt, o_drop_cnt} !==
        {1'b1, 8'd2, 16'd2, 8'd0}) begin
      errors++;
      $display("FAIL b2b_reload got v=%b len=%0d evt=%0d drop=%0d exp 1/2/2/0",
               o_valid, o_run_len, o_evt_cnt, o_drop_cnt);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_xfer got %b exp 0", o_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    i_ready = 1'b1;
    i_ok = 1'b1;
    repeat (300) tick();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_busy got %b exp 1", o_busy);
    end
    i_ok = 1'b0;
    tick();
    checks++;
    if ({o_valid, o_run_len} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL sat_len got v=%b len=%0d exp 1/255", o_valid, o_run_len);
    end
  endtask

  task automatic test_clear();
    do_reset();
    i_ready = 1'b1;
    i_ok = 1'b1;
    repeat (3) tick();
    i_ok = 1'b0;
    tick();
    tick();
    checks++;
    if (o_evt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL clr_pre got evt=%0d exp 1", o_evt_cnt);
    end
    i_ok = 1'b1;
    repeat (4) tick();
    i_ok = 1'b0;
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    checks++;
    if ({o_valid, o_run_len, o_evt_cnt} !== {1'b1, 8'd4, 16'd0}) begin
      errors++;
      $display("FAIL clr_collide got v=%b len=%0d evt=%0d exp 1/4/0",
               o_valid, o_run_len, o_evt_cnt);
    end
    // Clearing the drop counter leaves the held report intact.
    do_reset();
    i_ready = 1'b0;
    i_ok = 1'b1;
    repeat (2) tick();
    i_ok = 1'b0;
    tick();
    i_ok = 1'b1;
    repeat (2) tick();
    i_ok = 1'b0;
    tick();
    checks++;
    if ({o_drop_cnt, o_run_len} !== {8'd1, 8'd2}) begin
      errors++;
      $display("FAIL clr_drop_pre got drop=%0d len=%0d exp 1/2",
               o_drop_cnt, o_run_len);
    end
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    checks++;
    if ({o_drop_cnt, o_evt_cnt, o_valid, o_run_len} !==
        {8'd0, 16'd0, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL clr_drop got drop=%0d evt=%0d v=%b len=%0d exp 0/0/1/2",
               o_drop_cnt, o_evt_cnt, o_valid, o_run_len);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_ok = 1'b0;
    i_clr = 1'b0;
    i_ready = 1'b0;
    test_reset();
    test_normal();
    test_glitch();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_ok_run_monitor.md
Name: fsm_ok_run_monitor

Overview:
- Downstream consumer of the 1-bit Moore output of the 2-bit-input sequence-detector FSM (the "ok" flag).
- Tracks each contiguous high run of the ok flag and flags its start with a one-cycle pulse.
- Measures run length in cycles and reports each qualifying run as a record on a valid/ready channel.
- Keeps event and drop statistics for software/bench readout.

Parameters:
- CNT_W, 8: width of the run-length counter and of o_run_len.
- EVT_W, 16: width of the reported-event counter.
- MIN_RUN, 2: minimum run length in cycles for a run to be reported. Shorter runs are discarded as glitches.

Ports:
- clk  input  1  single clock. All logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_ok  input  1  ok flag from the upstream sequence-detector FSM.
- i_clr  input  1  synchronous clear of o_evt_cnt and o_drop_cnt only.
- i_ready  input  1  consumer ready for the report channel.
- o_rise  output  1  one-cycle pulse marking the start of an ok run.
- o_busy  output  1  high while the run FSM is in RUN.
- o_valid  output  1  report record valid.
- o_run_len  output  CNT_W  length of the reported run in cycles.
- o_evt_cnt  output  EVT_W  number of runs accepted into the report slot.
- o_drop_cnt  output  8  number of qualifying runs lost to backpressure.

Behaviour:
- Reset:
  - rst sampled high sets the state to IDLE.
  - Clears run_cnt, the report slot, o_rise, o_valid, o_run_len, o_evt_cnt and o_drop_cnt to 0.
  - rst takes priority over every other input.
- All outputs are registered.
- Run FSM has 2 states:
  - IDLE:
    - i_ok=1 → RUN, run_cnt<=1, o_rise<=1.
    - i_ok=0 → stay.
  - RUN:
    - i_ok=1 → stay, run_cnt<=run_cnt+1, saturating at 2^CNT_W-1.
    - i_ok=0 → IDLE, end-of-run event carrying the current run_cnt.
- o_rise is 1 only in the cycle after the edge that moved IDLE→RUN, otherwise 0. o_busy equals (state==RUN).
- Reset mid-run discards the run with no report. i_ok already high when rst deasserts counts as a new rise on the first sampled cycle.
- End-of-run with run_cnt < MIN_RUN: discarded. No report, no counter change.
- End-of-run with run_cnt >= MIN_RUN: load attempt on the one-entry report slot.
  - Slot empty, or slot valid with i_ready=1 in the same cycle: load o_run_len<=run_cnt, o_valid<=1, o_evt_cnt<=o_evt_cnt+1 (wraps modulo 2^EVT_W).
  - Otherwise the slot is held unchanged and o_drop_cnt increments, saturating at 255.
- Report handshake:
  - Transfer occurs when o_valid=1 and i_ready=1.
  - With no simultaneous load, o_valid<=0 after the transfer.
  - o_run_len is held stable while o_valid=1 and not transferred.
  - o_valid is never retracted without a transfer.
- Latency:
  - i_ok first sampled high at edge t gives o_rise high during cycle t+1.
  - i_ok last high at edge t+N-1 and sampled low at edge t+N gives o_valid high from cycle t+N+1, with o_run_len=N (saturated).
- i_clr:
  - Sets o_evt_cnt and o_drop_cnt to 0 and wins over a same-cycle increment.
  - Does not affect the FSM, run_cnt or the report slot.
- A new rise may occur in the cycle immediately after a run ends; the 1-cycle gap is handled. End-of-run and the next IDLE→RUN cannot coincide.

Test Plan:
- Reset: hold rst=1 for 2 cycles with i_ok=1 → all outputs 0. Release → o_rise=1 for exactly one cycle, o_busy=1.
- Normal report: i_ready=1, i_ok high for 5 cycles then low → o_rise 1 pulse, then o_valid=1 for 1 cycle with o_run_len=5, o_evt_cnt=1, o_drop_cnt=0.
- Glitch filter: i_ok high 1 cycle → o_rise pulses, o_valid stays 0, o_evt_cnt and o_drop_cnt unchanged.
- Backpressure: i_ready=0, runs of 3 and 4 separated by a 1-cycle gap → o_valid=1 with o_run_len=3 held, o_drop_cnt=1. Then i_ready=1 for 1 cycle → transfer, o_valid=0, o_evt_cnt=1.
- Saturation: CNT_W=8, i_ok high 300 cycles → report with o_run_len=255.
- Clear collision: i_clr=1 in the same cycle a qualifying run loads the slot → o_evt_cnt=0 afterwards, o_valid=1 with the correct o_run_len.
